// File: rtl/pattern_player.sv
`default_nettype none
// ============================================================================
// Module      : pattern_player
// Description : Fetches one 24-slot turn pattern from the bank and releases
//               its notes to the spawner, paced by beat ticks.
// Revision    : 1.0
// ============================================================================
module pattern_player #(
    parameter int SLOTS = 24,
    parameter int TW    = 3,
    parameter int SW    = 3,
    parameter int DW    = 2
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_in,
    input  logic [3:0]          turn_in,
    input  logic                abort_in,
    input  logic                beat_tick_in,
    output logic [3:0]          turn_out,
    input  logic                pattern_valid_in,
    input  logic [SLOTS*TW-1:0] timing_in,
    input  logic [SLOTS*SW-1:0] speed_in,
    input  logic [SLOTS*DW-1:0] direction_in,
    input  logic [SLOTS-1:0]    inversed_in,
    output logic                note_valid_out,
    input  logic                note_ready_in,
    output logic [SW-1:0]       note_speed_out,
    output logic [DW-1:0]       note_dir_out,
    output logic                note_inv_out,
    output logic [4:0]          note_idx_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                error_out
);

    localparam logic [4:0] c_last_slot = 5'(SLOTS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SLOTS*TW-1:0] r_timing;
    logic [SLOTS*SW-1:0] r_speed;
    logic [SLOTS*DW-1:0] r_dir;
    logic [SLOTS-1:0]    r_inv;
    logic [4:0]          r_slot;
    logic [TW-1:0]       r_cnt;
    logic [3:0]          r_turn;
    logic                r_error;

    logic [TW-1:0] w_tim [SLOTS];
    logic [SW-1:0] w_spd [SLOTS];
    logic [DW-1:0] w_dir [SLOTS];

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign w_tim[i] = r_timing[TW*i +: TW];
        assign w_spd[i] = r_speed[SW*i +: SW];
        assign w_dir[i] = r_dir[DW*i +: DW];
    end

    logic w_match;
    logic w_empty;
    logic w_last;
    logic w_emit;

    assign w_match = (r_cnt == w_tim[r_slot]);
    assign w_empty = (w_spd[r_slot] == '0);
    assign w_last  = (r_slot == c_last_slot);
    assign w_emit  = (r_state == S_EMIT);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_in) w_next = S_FETCH;
            S_FETCH: w_next = pattern_valid_in ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (w_match) begin
                    if (!w_empty)    w_next = S_EMIT;
                    else if (w_last) w_next = S_DONE;
                end
            end
            S_EMIT: begin
                if (note_ready_in) w_next = w_last ? S_DONE : S_WAIT;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort_in) w_next = S_IDLE;
    end

    // Bundles are captured once in FETCH; bank inputs are ignored afterwards.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_timing <= '0;
            r_speed  <= '0;
            r_dir    <= '0;
            r_inv    <= '0;
            r_slot   <= '0;
            r_cnt    <= '0;
            r_turn   <= '0;
            r_error  <= 1'b0;
        end else begin
            r_error <= 1'b0;
            if (abort_in) begin
                r_slot <= '0;
                r_cnt  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_in) r_turn <= turn_in;
                    end
                    S_FETCH: begin
                        if (pattern_valid_in) begin
                            r_timing <= timing_in;
                            r_speed  <= speed_in;
                            r_dir    <= direction_in;
                            r_inv    <= inversed_in;
                            r_slot   <= '0;
                            r_cnt    <= '0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (w_match) begin
                            if (w_empty && !w_last) begin
                                r_slot <= r_slot + 5'd1;
                                r_cnt  <= '0;
                            end
                        end else if (beat_tick_in) begin
                            r_cnt <= r_cnt + TW'(1);
                        end
                    end
                    S_EMIT: begin
                        if (note_ready_in && !w_last) begin
                            r_slot <= r_slot + 5'd1;
                            r_cnt  <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign turn_out       = r_turn;
    assign note_valid_out = w_emit;
    assign note_speed_out = w_emit ? w_spd[r_slot] : '0;
    assign note_dir_out   = w_emit ? w_dir[r_slot] : '0;
    assign note_inv_out   = w_emit ? r_inv[r_slot] : 1'b0;
    assign note_idx_out   = w_emit ? r_slot : '0;
    // busy drops while done pulses so the controller sees both together.
    assign busy_out       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done_out       = (r_state == S_DONE);
    assign error_out      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_pattern_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_player
// Description : Directed self-checking bench for pattern_player.
// Revision    : 1.0
// ============================================================================
module tb_pattern_player;

    localparam int SLOTS = 24;
    localparam int TW    = 3;
    localparam int SW    = 3;
    localparam int DW    = 2;

    logic                clk_in = 1'b0;
    logic                rst_n_in = 1'b0;
    logic                start_in = 1'b0;
    logic [3:0]          turn_in = '0;
    logic                abort_in = 1'b0;
    logic                beat_tick_in = 1'b0;
    logic [3:0]          turn_out;
    logic                pattern_valid_in = 1'b0;
    logic [SLOTS*TW-1:0] timing_in = '0;
    logic [SLOTS*SW-1:0] speed_in = '0;
    logic [SLOTS*DW-1:0] direction_in = '0;
    logic [SLOTS-1:0]    inversed_in = '0;
    logic                note_valid_out;
    logic                note_ready_in = 1'b0;
    logic [SW-1:0]       note_speed_out;
    logic [DW-1:0]       note_dir_out;
    logic                note_inv_out;
    logic [4:0]          note_idx_out;
    logic                busy_out;
    logic                done_out;
    logic                error_out;

    pattern_player #(.SLOTS(SLOTS), .TW(TW), .SW(SW), .DW(DW)) u_dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .start_in         (start_in),
        .turn_in          (turn_in),
        .abort_in         (abort_in),
        .beat_tick_in     (beat_tick_in),
        .turn_out         (turn_out),
        .pattern_valid_in (pattern_valid_in),
        .timing_in        (timing_in),
        .speed_in         (speed_in),
        .direction_in     (direction_in),
        .inversed_in      (inversed_in),
        .note_valid_out   (note_valid_out),
        .note_ready_in    (note_ready_in),
        .note_speed_out   (note_speed_out),
        .note_dir_out     (note_dir_out),
        .note_inv_out     (note_inv_out),
        .note_idx_out     (note_idx_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .error_out        (error_out)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-run observations; cycle c = c-th falling edge after start is driven.
    int   q_idx[$], q_cyc[$], q_spd[$], q_dir[$], q_inv[$];
    int   done_cnt, done_cyc, done_busy_bad, err_cnt, err_cyc, stall_bad;
    logic busy_h [128];
    logic valid_h [128];

    task automatic set_slot(input int i, input int t, input int s, input int d, input int v);
        timing_in[TW*i +: TW]    = TW'(t);
        speed_in[SW*i +: SW]     = SW'(s);
        direction_in[DW*i +: DW] = DW'(d);
        inversed_in[i]           = v[0];
    endtask

    task automatic clear_bank();
        timing_in = '0; speed_in = '0; direction_in = '0; inversed_in = '0;
    endtask

    task automatic load_full();
        for (int i = 0; i < SLOTS; i++) set_slot(i, 0, (i % 7) + 1, i % 4, i % 2);
    endtask

    task automatic load_beat();
        clear_bank();
        set_slot(0, 3, 1, 3, 0);
        set_slot(1, 0, 2, 0, 1);
    endtask

    task automatic play(input int ncyc, input logic [3:0] turn, input int ready_from,
                        input int tick_per, input int tick_off, input int abort_at,
                        input int rst_at);
        logic        pv;
        logic [10:0] pf, cur;
        pv = 1'b0; pf = '0;
        q_idx.delete(); q_cyc.delete(); q_spd.delete(); q_dir.delete(); q_inv.delete();
        done_cnt = 0; done_cyc = -1; done_busy_bad = 0; err_cnt = 0; err_cyc = -1; stall_bad = 0;
        for (int c = 0; c < 128; c++) begin busy_h[c] = 1'bx; valid_h[c] = 1'bx; end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk_in);
            start_in      = (c == 0);
            turn_in       = turn;
            note_ready_in = (c >= ready_from);
            beat_tick_in  = (tick_per != 0) && (c % tick_per == tick_off);
            abort_in      = (c == abort_at);
            busy_h[c]  = busy_out;
            valid_h[c] = note_valid_out;
            if (done_out) begin
                done_cnt++; done_cyc = c;
                if (busy_out) done_busy_bad++;
            end
            if (error_out) begin err_cnt++; err_cyc = c; end
            cur = {note_idx_out, note_speed_out, note_dir_out, note_inv_out};
            if (note_valid_out && pv && cur !== pf) stall_bad++;
            pv = note_valid_out && !note_ready_in;
            pf = cur;
            if (note_valid_out && note_ready_in) begin
                q_idx.push_back(int'(note_idx_out)); q_cyc.push_back(c);
                q_spd.push_back(int'(note_speed_out)); q_dir.push_back(int'(note_dir_out));
                q_inv.push_back(int'(note_inv_out));
            end
            if (c == rst_at) begin
                chk("pre_rst_busy", busy_out, 1);
                chk("pre_rst_turn", turn_out, turn);
                rst_n_in = 1'b0;
                #1;
                chk("rst_busy", busy_out, 0);
                chk("rst_turn", turn_out, 0);
                chk("rst_valid", note_valid_out, 0);
                #2 rst_n_in = 1'b1;
                break;
            end
        end
        @(negedge clk_in);
        start_in = 1'b0; beat_tick_in = 1'b0; abort_in = 1'b0; note_ready_in = 1'b0;
    endtask

    task automatic chk_note(input string tag, input int n, input int idx, input int cyc);
        if (q_idx.size() > n) begin
            chk({tag, "_idx"}, q_idx[n], idx);
            chk({tag, "_cyc"}, q_cyc[n], cyc);
        end else begin
            chk({tag, "_missing"}, q_idx.size(), n + 1);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_valid", note_valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_error", error_out, 0);
        chk("rst_turn", turn_out, 0);
        chk("rst_fields", {note_idx_out, note_speed_out, note_dir_out, note_inv_out}, 0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Bank miss
        pattern_valid_in = 1'b0;
        load_full();
        play(6, 4'd5, 0, 0, 0, -1, -1);
        chk("miss_err_cnt", err_cnt, 1);
        chk("miss_err_cyc", err_cyc, 2);
        chk("miss_busy_fetch", busy_h[1], 1);
        chk("miss_busy_after", busy_h[3], 0);
        chk("miss_notes", q_idx.size(), 0);
        chk("miss_done", done_cnt, 0);
        chk("miss_turn", turn_out, 5);

        // All-zero timing, every slot populated, ready high
        pattern_valid_in = 1'b1;
        play(56, 4'd3, 0, 0, 0, -1, -1);
        chk("full_notes", q_idx.size(), 24);
        for (int k = 0; k < 24; k++) begin
            chk_note("full", k, k, 3 + 2 * k);
            if (q_idx.size() > k) begin
                chk("full_spd", q_spd[k], (k % 7) + 1);
                chk("full_dir", q_dir[k], k % 4);
                chk("full_inv", q_inv[k], k % 2);
            end
        end
        chk("full_done_cnt", done_cnt, 1);
        chk("full_done_cyc", done_cyc, 50);
        chk("full_done_busy", done_busy_bad, 0);
        chk("full_idle_busy", busy_h[51], 0);

        // Beat spacing: ticks at c = 5, 15, 25
        load_beat();
        play(60, 4'd7, 0, 10, 5, -1, -1);
        chk("beat_notes", q_idx.size(), 2);
        chk("beat_early", valid_h[26], 0);
        chk_note("beat0", 0, 0, 27);
        chk_note("beat1", 1, 1, 29);
        chk("beat_done_cyc", done_cyc, 52);

        // Empty slots 1..22
        load_full();
        for (int i = 1; i <= 22; i++) set_slot(i, 0, 0, 0, 0);
        play(34, 4'd2, 0, 0, 0, -1, -1);
        chk("empty_notes", q_idx.size(), 2);
        chk_note("empty0", 0, 0, 3);
        chk_note("empty1", 1, 23, 27);
        chk("empty_done_cnt", done_cnt, 1);
        chk("empty_done_cyc", done_cyc, 28);

        // Backpressure with ticks every 3 cycles; bank scrambled mid-pattern
        clear_bank();
        set_slot(0, 0, 5, 2, 1);
        set_slot(1, 2, 3, 1, 0);
        fork
            play(58, 4'd1, 23, 3, 0, -1, -1);
            begin
                repeat (10) @(negedge clk_in);
                for (int i = 0; i < SLOTS; i++) set_slot(i, 7, 0, 0, 0);
            end
        join
        chk("bp_stall_stable", stall_bad, 0);
        begin
            int nv;
            nv = 0;
            for (int c = 3; c <= 22; c++) if (valid_h[c] === 1'b1) nv++;
            chk("bp_valid_held", nv, 20);
        end
        chk("bp_notes", q_idx.size(), 2);
        chk_note("bp0", 0, 0, 23);
        if (q_idx.size() > 0) begin
            chk("bp0_spd", q_spd[0], 5);
            chk("bp0_dir", q_dir[0], 2);
            chk("bp0_inv", q_inv[0], 1);
        end
        chk_note("bp1", 1, 1, 29);
        if (q_idx.size() > 1) chk("bp1_spd", q_spd[1], 3);
        chk("bp_done_cyc", done_cyc, 52);

        // Abort during EMIT
        load_full();
        play(20, 4'd3, 99, 0, 0, 4, -1);
        chk("abort_valid_before", valid_h[4], 1);
        chk("abort_valid_after", valid_h[5], 0);
        chk("abort_busy_after", busy_h[5], 0);
        chk("abort_done", done_cnt, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_notes", q_idx.size(), 0);

        // Reset mid-WAIT, then replay from slot 0
        load_beat();
        play(12, 4'd9, 0, 10, 5, -1, 10);
        play(60, 4'd9, 0, 10, 5, -1, -1);
        chk("replay_notes", q_idx.size(), 2);
        chk_note("replay0", 0, 0, 27);
        chk_note("replay1", 1, 1, 29);
        chk("replay_done_cyc", done_cyc, 52);
        chk("replay_turn", turn_out, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
